// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: self-fills with mem[i] = i after reset, then serves
// fixed-latency pipelined reads and single-cycle writes with error and activity tracking.
module avalon_mem_responder #(
  parameter int ADDR_W       = 9,
  parameter int READ_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        stall_in,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic        fill_done,
  output logic        protocol_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {FILL, SERVE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fill_idx_reg, fill_idx_next;

  logic [31:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] vld_pipe_reg;
  logic [READ_LATENCY-1:0] ok_pipe_reg;
  logic [31:0]             data_pipe_reg [READ_LATENCY];

  logic        err_reg;
  logic [15:0] rd_count_reg, wr_count_reg;

  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              accept, rd_acc, wr_acc, dual_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign s_waitrequest = (state_reg == FILL) || stall_in;
  assign in_range      = (s_address[31:ADDR_W] == '0);
  assign idx           = s_address[ADDR_W-1:0];
  assign accept        = (s_read || s_write) && !s_waitrequest;
  assign wr_acc        = accept && s_write;
  // A combined read+write is treated as a write; the read half is dropped.
  assign rd_acc        = accept && s_read && !s_write;
  assign dual_acc      = accept && s_read && s_write;

  always_comb begin
    state_next    = state_reg;
    fill_idx_next = fill_idx_reg;
    case (state_reg)
      FILL: begin
        fill_idx_next = fill_idx_reg + 1'b1;
        if (fill_idx_reg == '1) state_next = SERVE;
      end
      SERVE: ;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      fill_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_idx_reg <= fill_idx_next;
    end
  end

  // Single write port shared between the fill sweep and master writes.
  assign mem_we    = (state_reg == FILL) || (wr_acc && in_range);
  assign mem_waddr = (state_reg == FILL) ? fill_idx_reg : idx;
  assign mem_wdata = (state_reg == FILL) ? 32'(fill_idx_reg) : s_writedata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read data is captured at acceptance and then only shifts, so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rd_acc) data_pipe_reg[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) data_pipe_reg[i] <= data_pipe_reg[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_reg <= '0;
      ok_pipe_reg  <= '0;
    end else begin
      vld_pipe_reg[0] <= rd_acc;
      ok_pipe_reg[0]  <= in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        ok_pipe_reg[i]  <= ok_pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if ((accept && !in_range) || dual_acc) err_reg <= 1'b1;
      if (rd_acc && rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
      if (wr_acc && wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  // Out-of-range reads return zero; data is also forced to zero whenever no word is valid.
  assign s_readdatavalid = vld_pipe_reg[READ_LATENCY-1];
  assign s_readdata      = (vld_pipe_reg[READ_LATENCY-1] && ok_pipe_reg[READ_LATENCY-1])
                           ? data_pipe_reg[READ_LATENCY-1] : 32'h0;
  assign fill_done       = (state_reg == SERVE);
  assign protocol_err    = err_reg;
  assign rd_count        = rd_count_reg;
  assign wr_count        = wr_count_reg;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Randomized bench for avalon_mem_responder against a transaction-level model
// (array memory plus a queue of expected read responses tagged with their due cycle).
module tb_avalon_mem_responder;

  localparam int ADDR_W = 9;
  localparam int LAT    = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        stall_in;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        fill_done;
  logic        protocol_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  avalon_mem_responder #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .stall_in       (stall_in),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .fill_done      (fill_done),
    .protocol_err   (protocol_err),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] model_mem [DEPTH];
  rsp_t        rsp_q [$];
  int          fill_cnt = 0;
  int          cyc = 0;
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_err = 0;
  bit          m_inr;
  rsp_t        m_rsp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt = 0;
      rsp_q.delete();
      m_rd  = 0;
      m_wr  = 0;
      m_err = 0;
    end else begin
      cyc++;
      if (fill_cnt < DEPTH) begin
        fill_cnt++;
        if (fill_cnt == DEPTH)
          for (int i = 0; i < DEPTH; i++) model_mem[i] = i;
      end else if (!stall_in && (s_read || s_write)) begin
        m_inr = (s_address < DEPTH);
        if (s_write) begin
          if (m_wr < 65535) m_wr++;
          if (m_inr) model_mem[s_address[ADDR_W-1:0]] = s_writedata;
          else m_err = 1;
          if (s_read) m_err = 1;
        end else begin
          if (m_rd < 65535) m_rd++;
          if (!m_inr) m_err = 1;
          m_rsp.due  = cyc + LAT - 1;
          m_rsp.data = m_inr ? model_mem[s_address[ADDR_W-1:0]] : 32'h0;
          rsp_q.push_back(m_rsp);
          $display("read  accepted addr=%h exp_data=%h due=%0d", s_address, m_rsp.data, m_rsp.due);
        end
        if (s_write)
          $display("write accepted addr=%h data=%h rd_also=%0d", s_address, s_writedata, s_read);
      end
    end
  end

  bit exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_valid",    32'(s_readdatavalid), 32'd0);
      check_eq("rst_rdata",    s_readdata,           32'd0);
      check_eq("rst_filldone", 32'(fill_done),       32'd0);
      check_eq("rst_err",      32'(protocol_err),    32'd0);
      check_eq("rst_rdcnt",    32'(rd_count),        32'd0);
      check_eq("rst_wrcnt",    32'(wr_count),        32'd0);
    end else begin
      check_eq("waitreq",  32'(s_waitrequest), 32'((fill_cnt < DEPTH) || stall_in));
      check_eq("filldone", 32'(fill_done),     32'(fill_cnt >= DEPTH));
      check_eq("proterr",  32'(protocol_err),  32'(m_err));
      check_eq("rd_count", 32'(rd_count),      32'(m_rd));
      check_eq("wr_count", 32'(wr_count),      32'(m_wr));
      exp_v = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      check_eq("rvalid", 32'(s_readdatavalid), 32'(exp_v));
      if (exp_v) begin
        check_eq("rdata", s_readdata, rsp_q[0].data);
        $display("read  returned data=%h exp=%h", s_readdata, rsp_q[0].data);
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit st);
    s_read      = rd;
    s_write     = wr;
    s_address   = a;
    s_writedata = d;
    stall_in    = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    int          ai;
    bit          st, rd, wr;
    logic [31:0] addr;

    rst_n = 1'b0;
    s_read = 0; s_write = 0; s_address = '0; s_writedata = '0; stall_in = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(DEPTH + 4);

    // Full back-to-back sweep of the filled memory
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'(i), 32'h0, 0);
    idle(LAT + 2);
    check_eq("sweep_rdcnt", 32'(rd_count), 32'd512);

    // Read before write keeps old data; read right after write sees new data
    drive(1, 0, 32'd5, 32'h0, 0);
    drive(0, 1, 32'd5, 32'hDEADBEEF, 0);
    drive(1, 0, 32'd5, 32'h0, 0);
    idle(LAT + 2);

    // Stall in the middle of a burst; the held request resumes in order
    ai = 100;
    for (int i = 0; i < 20; i++) begin
      st = (i >= 6 && i < 10);
      drive(1, 0, 32'(ai), 32'h0, st);
      if (!st) ai++;
    end
    idle(LAT + 2);

    // Out-of-range read and dual read+write
    drive(1, 0, 32'h200, 32'h0, 0);
    drive(1, 1, 32'd7, 32'h12345678, 0);
    drive(1, 0, 32'd7, 32'h0, 0);
    idle(LAT + 2);
    check_eq("dir_err", 32'(protocol_err), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 7) == 0);
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      drive(rd, wr, addr, $urandom, st);
    end
    idle(LAT + 2);

    // Reset with two reads in flight
    drive(1, 0, 32'd10, 32'h0, 0);
    drive(1, 0, 32'd11, 32'h0, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(LAT + 1);
    check_eq("post_rst_rdcnt", 32'(rd_count), 32'd0);
    check_eq("post_rst_fill",  32'(fill_done), 32'd0);
    idle(DEPTH + 2);
    for (int i = 0; i < 16; i++) drive(1, 0, 32'(i * 3), 32'h0, 0);
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
